// File: rtl/bp_fe_queue_buffer_pkg.sv
// rtl/bp_fe_queue_buffer_pkg.sv - core-interface types and config helpers for the FE queue buffer
package bp_fe_queue_buffer_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg  = 1'b0,
    e_bp_unicore_cfg  = 1'b1
  } bp_params_e;

  typedef enum logic [0:0] {
    e_fe_fetch     = 1'b0,
    e_fe_exception = 1'b1
  } bp_fe_queue_type_e;

  typedef struct packed {
    bp_fe_queue_type_e msg_type;
    logic [38:0]       pc;
    logic [31:0]       instr;
  } bp_fe_queue_s;

  // Every supported configuration currently carries the same FE queue packet
  function automatic int bp_fe_queue_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return $bits(bp_fe_queue_s);
      default:          return $bits(bp_fe_queue_s);
    endcase
  endfunction

endpackage

// File: rtl/bp_fe_queue_ptr.sv
// rtl/bp_fe_queue_ptr.sv - wrap-bit pointer register with increment, load and sync reset
module bp_fe_queue_ptr #(
  parameter int width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               inc_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  output logic [width_p-1:0] ptr_o
);

  // Reset wins over load, load wins over increment; the MSB is the wrap bit
  always_ff @(posedge clk_i) begin
    if (reset_i)
      ptr_o <= '0;
    else if (load_i)
      ptr_o <= load_val_i;
    else if (inc_i)
      ptr_o <= ptr_o + width_p'(1);
  end

endmodule

// File: rtl/bp_fe_queue_buffer.sv
// rtl/bp_fe_queue_buffer.sv - elastic FE-to-BE packet FIFO with flush; optional BP_FE_QUEUE_BYPASS_EN
module bp_fe_queue_buffer
  import bp_fe_queue_buffer_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int els_p = 8,
  localparam int ptr_width_lp = $clog2(els_p),
  localparam int fe_queue_width_lp = bp_fe_queue_width(bp_params_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [fe_queue_width_lp-1:0] fe_queue_i,
  input  logic                         fe_queue_v_i,
  output logic                         fe_queue_ready_o,
  output logic [fe_queue_width_lp-1:0] fe_queue_o,
  output logic                         fe_queue_v_o,
  input  logic                         fe_queue_ready_i,
  input  logic                         flush_i,
  output logic [ptr_width_lp:0]        count_o
);

  logic [fe_queue_width_lp-1:0] mem [els_p];
  logic [ptr_width_lp:0]        wptr, rptr;
  logic                         empty, full;
  logic                         enq, deq, bypass, bypass_taken;
  logic                         wr_en, rd_inc;

  assign empty = (wptr == rptr);
  assign full  = (wptr[ptr_width_lp-1:0] == rptr[ptr_width_lp-1:0])
               & (wptr[ptr_width_lp] != rptr[ptr_width_lp]);

  // Ready depends only on registered state and local control, never on BE ready
  assign fe_queue_ready_o = ~full & ~flush_i & ~reset_i;
  assign enq = fe_queue_v_i & fe_queue_ready_o;

`ifdef BP_FE_QUEUE_BYPASS_EN
  assign bypass = empty & fe_queue_v_i & ~flush_i & ~reset_i;
`else
  assign bypass = 1'b0;
`endif

  assign fe_queue_v_o = ~empty | bypass;
  assign fe_queue_o   = bypass ? fe_queue_i : mem[rptr[ptr_width_lp-1:0]];
  assign deq          = fe_queue_v_o & fe_queue_ready_i;

  // A bypassed packet the BE takes immediately never touches storage or pointers
  assign bypass_taken = bypass & fe_queue_ready_i;
  assign wr_en        = enq & ~bypass_taken;
  assign rd_inc       = deq & ~bypass_taken;

  assign count_o = wptr - rptr;

  bp_fe_queue_ptr #(.width_p(ptr_width_lp+1)) u_wptr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .inc_i      (wr_en),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (wptr)
  );

  // Flush snaps the read pointer to the write pointer; the write pointer is idle then
  bp_fe_queue_ptr #(.width_p(ptr_width_lp+1)) u_rptr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .inc_i      (rd_inc),
    .load_i     (flush_i),
    .load_val_i (wptr),
    .ptr_o      (rptr)
  );

  // Packet storage: synchronous write at the write index
  always_ff @(posedge clk_i) begin
    if (wr_en)
      mem[wptr[ptr_width_lp-1:0]] <= fe_queue_i;
  end

endmodule

// File: tb/tb_bp_fe_queue_buffer.sv
// tb/tb_bp_fe_queue_buffer.sv - directed self-checking bench for bp_fe_queue_buffer
module tb_bp_fe_queue_buffer;
  import bp_fe_queue_buffer_pkg::*;

  localparam int W = $bits(bp_fe_queue_s);

  logic         clk = 1'b0;
  logic         reset_i;
  logic [W-1:0] fe_queue_i;
  logic         fe_queue_v_i;
  logic         fe_queue_ready_o;
  logic [W-1:0] fe_queue_o;
  logic         fe_queue_v_o;
  logic         fe_queue_ready_i;
  logic         flush_i;
  logic [3:0]   count_o;

  int total = 0;
  int bad   = 0;
  int rx;

  bp_fe_queue_buffer dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .fe_queue_i       (fe_queue_i),
    .fe_queue_v_i     (fe_queue_v_i),
    .fe_queue_ready_o (fe_queue_ready_o),
    .fe_queue_o       (fe_queue_o),
    .fe_queue_v_o     (fe_queue_v_o),
    .fe_queue_ready_i (fe_queue_ready_i),
    .flush_i          (flush_i),
    .count_o          (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_i = 1'b1; fe_queue_v_i = 1'b0; fe_queue_ready_i = 1'b0;
    flush_i = 1'b0; fe_queue_i = '0;
    step(); step();
    settle();
    chk("rst_ready", W'(fe_queue_ready_o), W'(0));
    chk("rst_v", W'(fe_queue_v_o), W'(0));
    chk("rst_count", W'(count_o), W'(0));

    // Single enqueue with BE stalled
    reset_i = 1'b0; fe_queue_v_i = 1'b1; fe_queue_i = W'(32'hA);
    settle();
    chk("post_rst_ready", W'(fe_queue_ready_o), W'(1));
`ifdef BP_FE_QUEUE_BYPASS_EN
    chk("enq1_bypass_v", W'(fe_queue_v_o), W'(1));
    chk("enq1_bypass_data", fe_queue_o, W'(32'hA));
`else
    chk("enq1_same_cycle_v", W'(fe_queue_v_o), W'(0));
`endif
    step();
    fe_queue_v_i = 1'b0;
    settle();
    chk("enq1_v", W'(fe_queue_v_o), W'(1));
    chk("enq1_data", fe_queue_o, W'(32'hA));
    chk("enq1_count", W'(count_o), W'(1));
    fe_queue_ready_i = 1'b1;
    step();
    fe_queue_ready_i = 1'b0;
    settle();
    chk("deq1_v", W'(fe_queue_v_o), W'(0));
    chk("deq1_count", W'(count_o), W'(0));

    // Fill to full with BE stalled
    for (int i = 0; i < 8; i++) begin
      fe_queue_v_i = 1'b1; fe_queue_i = W'(32'h10 + i);
      settle();
      chk("fill_ready", W'(fe_queue_ready_o), W'(1));
      step();
    end
    fe_queue_v_i = 1'b0;
    settle();
    chk("full_ready", W'(fe_queue_ready_o), W'(0));
    chk("full_count", W'(count_o), W'(8));
    chk("full_head", fe_queue_o, W'(32'h10));

    // Enqueue refused while full even with a simultaneous dequeue
    fe_queue_v_i = 1'b1; fe_queue_i = W'(32'h99); fe_queue_ready_i = 1'b1;
    settle();
    chk("full_deq_ready", W'(fe_queue_ready_o), W'(0));
    step();
    fe_queue_v_i = 1'b0; fe_queue_ready_i = 1'b0;
    settle();
    chk("after_full_count", W'(count_o), W'(7));
    chk("after_full_ready", W'(fe_queue_ready_o), W'(1));
    chk("after_full_head", fe_queue_o, W'(32'h11));

    // Drain remaining seven in order
    fe_queue_ready_i = 1'b1;
    for (int i = 1; i < 8; i++) begin
      settle();
      chk("drain_data", fe_queue_o, W'(32'h10 + i));
      step();
    end
    fe_queue_ready_i = 1'b0;
    settle();
    chk("drain_v", W'(fe_queue_v_o), W'(0));
    chk("drain_count", W'(count_o), W'(0));

    // Stream 20 packets with both sides always ready
    rx = 0;
    fe_queue_ready_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      fe_queue_v_i = (i < 20);
      fe_queue_i   = W'(32'h100 + i);
      settle();
      if (fe_queue_v_o) begin
        chk("stream_data", fe_queue_o, W'(32'h100 + rx));
        rx++;
      end
      step();
      if (i >= 20 && rx == 20) break;
    end
    fe_queue_v_i = 1'b0; fe_queue_ready_i = 1'b0;
    settle();
    chk("stream_rx", W'(rx), W'(20));
    chk("stream_count", W'(count_o), W'(0));

    // Flush with 5 held while BE dequeues and FE offers a packet
    for (int i = 0; i < 5; i++) begin
      fe_queue_v_i = 1'b1; fe_queue_i = W'(32'h200 + i);
      step();
    end
    fe_queue_v_i = 1'b0;
    settle();
    chk("pre_flush_count", W'(count_o), W'(5));
    flush_i = 1'b1; fe_queue_ready_i = 1'b1; fe_queue_v_i = 1'b1; fe_queue_i = W'(32'h2FF);
    settle();
    chk("flush_ready", W'(fe_queue_ready_o), W'(0));
    chk("flush_head_v", W'(fe_queue_v_o), W'(1));
    chk("flush_head", fe_queue_o, W'(32'h200));
    step();
    flush_i = 1'b0; fe_queue_ready_i = 1'b0; fe_queue_v_i = 1'b0;
    settle();
    chk("post_flush_v", W'(fe_queue_v_o), W'(0));
    chk("post_flush_count", W'(count_o), W'(0));
    chk("post_flush_ready", W'(fe_queue_ready_o), W'(1));

    // Empty buffer, FE valid and BE ready together
    fe_queue_v_i = 1'b1; fe_queue_i = W'(32'h300); fe_queue_ready_i = 1'b1;
    settle();
`ifdef BP_FE_QUEUE_BYPASS_EN
    chk("byp_v", W'(fe_queue_v_o), W'(1));
    chk("byp_data", fe_queue_o, W'(32'h300));
    step();
    fe_queue_v_i = 1'b0; fe_queue_ready_i = 1'b0;
    settle();
    chk("byp_count", W'(count_o), W'(0));
    chk("byp_after_v", W'(fe_queue_v_o), W'(0));
`else
    chk("nobyp_v", W'(fe_queue_v_o), W'(0));
    step();
    fe_queue_v_i = 1'b0;
    settle();
    chk("nobyp_next_v", W'(fe_queue_v_o), W'(1));
    chk("nobyp_next_data", fe_queue_o, W'(32'h300));
    chk("nobyp_next_count", W'(count_o), W'(1));
    step();
    fe_queue_ready_i = 1'b0;
    settle();
    chk("nobyp_drain_count", W'(count_o), W'(0));
`endif

    // Reset with 3 entries held
    for (int i = 0; i < 3; i++) begin
      fe_queue_v_i = 1'b1; fe_queue_i = W'(32'h400 + i);
      step();
    end
    fe_queue_v_i = 1'b0;
    settle();
    chk("pre_rst_count", W'(count_o), W'(3));
    reset_i = 1'b1;
    settle();
    chk("in_rst_ready", W'(fe_queue_ready_o), W'(0));
    step();
    settle();
    chk("mid_rst_v", W'(fe_queue_v_o), W'(0));
    chk("mid_rst_count", W'(count_o), W'(0));
    chk("mid_rst_ready", W'(fe_queue_ready_o), W'(0));
    reset_i = 1'b0;
    settle();
    chk("after_rst_ready", W'(fe_queue_ready_o), W'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_fe_queue_buffer.md
# bp_fe_queue_buffer

Elastic FIFO between the front-end fetch output and the back-end scheduler's FE queue input. Holds up to `els_p` fetch packets (instructions and exceptions) so the FE can run ahead of issue. On a BE redirect, the BE pulses `flush_i` and every buffered entry is discarded. Decouples FE timing from BE backpressure without any combinational ready path from BE to FE.

## Interface

Parameters:
- `bp_params_p`, default `e_bp_default_cfg`: processor configuration; supplies `fe_queue_width_lp`.
- `els_p`, default 8: entry count; must be a power of two, ≥2.
- `ptr_width_lp`, default `$clog2(els_p)`: index width. Localparam.

Ports:
- `clk_i`, in, 1: clock; all state updates on the rising edge.
- `reset_i`, in, 1: synchronous, active-high reset.
- `fe_queue_i`, in, `fe_queue_width_lp`: packet from the FE.
- `fe_queue_v_i`, in, 1: FE packet valid.
- `fe_queue_ready_o`, out, 1: buffer can accept a packet. An enqueue occurs when `fe_queue_v_i & fe_queue_ready_o`.
- `fe_queue_o`, out, `fe_queue_width_lp`: head packet to the BE.
- `fe_queue_v_o`, out, 1: head packet valid.
- `fe_queue_ready_i`, in, 1: BE accepts the head. A dequeue occurs when `fe_queue_v_o & fe_queue_ready_i`.
- `flush_i`, in, 1: BE redirect; clears all entries.
- `count_o`, out, `ptr_width_lp+1`: current occupancy, 0..`els_p`.

## Operation

Storage and pointers:
- Circular buffer of `els_p` entries.
- Read and write pointers are each `ptr_width_lp+1` bits; the top bit is a wrap bit.
- Empty when the pointers are fully equal.
- Full when the indices are equal and the wrap bits differ.
- Pointers increment modulo `2*els_p`, so the index wraps from `els_p-1` to 0 and the wrap bit toggles.

Handshake rules:
- `fe_queue_ready_o = ~full & ~flush_i & ~reset_i`. It is registered-state only: no dependence on `fe_queue_ready_i`.
- When full, an enqueue is refused even if a dequeue happens in the same cycle. The slot frees next cycle.
- Enqueue and dequeue in the same cycle with neither empty nor full: both pointers advance and the count is unchanged.
- `fe_queue_v_o = ~empty`. `fe_queue_o` shows the entry at the read index.

Flush:
- No enqueue can complete in a flush cycle, because ready is low.
- A dequeue in the flush cycle completes normally; the BE consumed it.
- Next cycle, the read pointer is set equal to the write pointer: empty, count 0.

Count:
- `count_o` equals the write pointer minus the read pointer, computed in `ptr_width_lp+1` bits. Unsigned wrap-around makes the subtraction correct.

Reset:
- Asserting `reset_i` mid-operation discards all contents.

## Timing

- Reset values: pointers 0, `fe_queue_v_o`=0, `fe_queue_ready_o`=0 during reset and 1 the cycle after, `count_o`=0. `fe_queue_o` is don't-care while `fe_queue_v_o`=0.
- Base enqueue-to-visible latency is 1 cycle: an enqueue at cycle t raises `fe_queue_v_o` at t+1.
- Dequeue at cycle t shows the next head at t+1.
- Flush at cycle t gives `fe_queue_v_o`=0 and `count_o`=0 at t+1, and `fe_queue_ready_o`=1 at t+1.
- Sustained throughput is 1 packet/cycle in and 1 packet/cycle out.

## Configuration

`BP_FE_QUEUE_BYPASS_EN`:
- Defined:
  - When the buffer is empty and `fe_queue_v_i` is high with no flush, `fe_queue_o`/`fe_queue_v_o` forward the input combinationally in the same cycle.
  - If the BE also accepts that cycle, the packet is never written and neither pointer moves.
  - This adds an FE→BE combinational path but keeps no BE→FE path.
  - `flush_i` suppresses the bypass.
- Undefined: no bypass; strict 1-cycle latency as in Timing.

## Structure

- Shared package: no new typedefs. Use the existing `bp_fe_queue_s` from the core-interface declarations.
- Sub-module `bp_fe_queue_ptr`: a wrap-bit pointer register with increment, load, and synchronous reset, instantiated twice.
- Storage: plain flop array, write-synchronous, read-asynchronous.

## Test plan

- Reset, then enqueue 0xA at cycle 1 with BE ready=0: `fe_queue_v_o`=1 at cycle 2 (same cycle with bypass), `count_o`=1.
- Enqueue 8 packets with BE stalled (`els_p`=8): ready drops after the 8th, `count_o`=8. Then assert enqueue and dequeue together: dequeue only, count 7, ready=1 the next cycle.
- Stream 20 packets with FE and BE both always valid/ready: in-order delivery, pointers wrap twice, no loss or duplication.
- With 5 entries held, pulse `flush_i` while the BE dequeues: the head is consumed, then next cycle `v_o`=0, `count_o`=0, and an FE packet offered during the flush is not accepted.
- With the bypass macro defined, buffer empty, FE valid and BE ready in the same cycle: packet delivered that cycle and `count_o` stays 0. Macro undefined: delivered the next cycle.
- Assert `reset_i` with 3 entries held: all outputs return to reset values the next cycle.
